// File: rtl/mem_io_responder_pkg.sv
// Shared bus definitions for the memory/IO responder and the CPU that drives it:
// command encodings, IO register addresses and the address-region decoder.
package mem_io_responder_pkg;

    typedef enum logic [2:0] {
        MNONE  = 3'b001,
        MREAD  = 3'b010,
        MWRITE = 3'b100
    } mem_cmd_e;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_NONE
    } region_e;

    // Where read_data comes from after a read: live RAM output or a held word.
    typedef enum logic {
        SRC_RAM,
        SRC_HOLD
    } rd_src_e;

    function automatic region_e decode_region(input logic [15:0] addr,
                                              input int unsigned ram_words);
        if (32'(addr) < ram_words)         return REG_RAM;
        else if (addr == 16'(LED_ADDR))    return REG_LED;
        else if (addr == 16'(SW_ADDR))     return REG_SW;
        else                               return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Command/response bus between the CPU (master) and the memory/IO responder (slave).
interface mem_io_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
);
    logic [2:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, read_valid
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, read_valid
    );
endinterface

// File: rtl/mem_io_responder_ram_sp.sv
// Single-port RAM: synchronous write, registered read that only updates on a read
// enable, so the output word holds between reads.
module ram_sp #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_io_responder.sv
// Memory-mapped responder: 256-word RAM, write-only LED register, synchronised
// switch register, sticky error flag and an accepted-write counter.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    mem_io_responder_if.slave   bus,
    input  logic [9:0]          sw,
    output logic [7:0]          led,
    output logic                err,
    output logic [7:0]          wr_count
);
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    region_e           region_d;
    logic              cmd_ok_d;
    logic              is_rd_d;
    logic              is_wr_d;
    logic              ram_re_d;
    logic              ram_we_d;
    logic              bad_d;
    logic [DATA_W-1:0] ram_rdata;

    logic [9:0]        sw_meta_q;
    logic [9:0]        sw_sync_q;
    logic [7:0]        led_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              valid_q;
    rd_src_e           src_q;
    logic [DATA_W-1:0] hold_q;

    always_comb begin
        region_d = decode_region(16'(bus.mem_addr), RAM_WORDS);
        cmd_ok_d = (bus.mem_cmd == MNONE) || (bus.mem_cmd == MREAD) ||
                   (bus.mem_cmd == MWRITE);
        is_rd_d  = !reset && (bus.mem_cmd == MREAD);
        is_wr_d  = !reset && (bus.mem_cmd == MWRITE);
        ram_re_d = is_rd_d && (region_d == REG_RAM);
        ram_we_d = is_wr_d && (region_d == REG_RAM);
        bad_d    = !cmd_ok_d ||
                   ((bus.mem_cmd == MWRITE) && ((region_d == REG_SW) || (region_d == REG_NONE))) ||
                   ((bus.mem_cmd == MREAD) && (region_d == REG_NONE));
    end

    ram_sp #(
        .WIDTH (DATA_W),
        .DEPTH (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_d),
        .re    (ram_re_d),
        .addr  (bus.mem_addr[RAM_AW-1:0]),
        .wdata (bus.write_data),
        .rdata (ram_rdata)
    );

    // Non-RAM reads latch their word in hold_q; RAM reads use the RAM's own
    // output register, so both paths give the same single-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            src_q     <= SRC_HOLD;
            hold_q    <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            valid_q   <= is_rd_d;
            if (is_rd_d) begin
                src_q  <= (region_d == REG_RAM) ? SRC_RAM : SRC_HOLD;
                hold_q <= (region_d == REG_SW) ? DATA_W'(sw_sync_q) : '0;
            end
            if (is_wr_d && (region_d == REG_LED)) led_q <= bus.write_data[7:0];
            if (is_wr_d && ((region_d == REG_RAM) || (region_d == REG_LED)))
                cnt_q <= cnt_q + 8'd1;
            if (bad_d) err_q <= 1'b1;
        end
    end

    assign bus.read_data  = (src_q == SRC_RAM) ? ram_rdata : hold_q;
    assign bus.read_valid = valid_q;
    assign led            = led_q;
    assign err            = err_q;
    assign wr_count       = cnt_q;
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter DATA_W, 16, data word width in bits.
REQ-002 Parameter ADDR_W, 9, memory address width in bits.
REQ-003 Parameter RAM_WORDS, 256, RAM depth in words, mapped at 0x000-0x0FF.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port mem_cmd  input  3  one-hot command: MNONE=3'b001, MREAD=3'b010, MWRITE=3'b100.
REQ-007 Port mem_addr  input  ADDR_W  word address of the current command.
REQ-008 Port write_data  input  DATA_W  store data, sampled with MWRITE.
REQ-009 Port read_data  output  DATA_W  registered read result.
REQ-010 Port read_valid  output  1  high for exactly the cycle read_data holds the result of the previous cycle's MREAD.
REQ-011 Port sw  input  10  asynchronous slide-switch inputs.
REQ-012 Port led  output  8  LED register contents.
REQ-013 Port err  output  1  sticky error flag.
REQ-014 Port wr_count  output  8  count of accepted MWRITE commands.

Function
REQ-015 The address map SHALL be: 0x000-0x0FF RAM; 0x100 LED register (write-only); 0x140 switch register (read-only); all other addresses unmapped.
REQ-016 MREAD in cycle N SHALL produce read_data and read_valid=1 in cycle N+1, giving one cycle of latency.
REQ-017 Reads SHALL return RAM[mem_addr[7:0]] for RAM addresses, {6'b0, sw_sync} for 0x140, and 16'h0000 for 0x100 or unmapped addresses.
REQ-018 read_data SHALL hold its last value while read_valid=0, and read_valid SHALL be 0 in any cycle not following an MREAD.
REQ-019 Back-to-back MREAD over consecutive cycles SHALL yield read_valid=1 on each following cycle with the matching data, giving full throughput.
REQ-020 MWRITE to RAM SHALL update the addressed word at the clock edge that samples the command.
REQ-021 MWRITE to 0x100 SHALL load led with write_data[7:0].
REQ-022 MREAD in cycle N+1 to the address written in cycle N SHALL return the new data; no bypass is required because the read is issued after the write.
REQ-023 sw SHALL pass through a two-flop synchronizer (sw_sync); a change on sw SHALL be visible to reads issued no later than 2 cycles after it.
REQ-024 wr_count SHALL increment by 1 for every MWRITE to a mapped writable address (RAM or 0x100), wrapping from 255 to 0.
REQ-025 err SHALL be set and held until reset by any of: mem_cmd not one-hot, including 3'b000; MWRITE to 0x140 or an unmapped address; MREAD to an unmapped address.
REQ-026 An illegal mem_cmd SHALL be treated as MNONE: no RAM or LED update, read_valid=0 next cycle, and wr_count unchanged.
REQ-027 A write to 0x140 or an unmapped address SHALL be ignored apart from setting err.

Reset
REQ-028 While reset=1, read_data=0, read_valid=0, led=0, err=0, wr_count=0, and both synchronizer stages SHALL be cleared.
REQ-029 A command presented in a cycle with reset=1 SHALL be ignored, and RAM contents SHALL NOT be cleared.
REQ-030 When reset is asserted in the cycle after an MREAD, read_valid SHALL be 0 in the next cycle.

Structure
REQ-031 The mem_cmd encodings (MNONE/MREAD/MWRITE) and address constants (LED_ADDR=0x100, SW_ADDR=0x140) SHALL reside in a shared package or include file, also used by the CPU.
REQ-032 RAM storage SHALL be a single sub-module, ram_sp: single-port, synchronous write, registered read, parameterized by width and depth, with an optional init-file parameter.
REQ-033 Address decode, error logic, LED register, synchronizer and counter SHALL reside in mem_io_responder.

Verification
REQ-034 Reset, then MWRITE 0x005 data 16'hBEEF, then MREAD 0x005 in the next cycle -> read_data=16'hBEEF with read_valid=1 one cycle after the read; wr_count=1.
REQ-035 MREAD to 0x003, 0x004 and 0x005 in three consecutive cycles with preloaded values 1, 2, 3 -> read_valid=1 for three consecutive cycles with data 1, 2, 3 in order.
REQ-036 MWRITE 0x100 data 16'h12A5 -> led=8'hA5; then sw=10'h2C3 held for 3 cycles and MREAD 0x140 -> read_data=16'h02C3.
REQ-037 mem_cmd=3'b011 at 0x010 -> err=1, RAM[0x10] unchanged, read_valid=0; err stays 1 through later legal traffic until reset.
REQ-038 MWRITE 0x1FF, then MREAD 0x1FF -> err=1, read_data=0, wr_count unchanged; 256 legal writes -> wr_count wraps to 0.
REQ-039 MREAD, then reset asserted in the following cycle -> read_valid=0, read_data=0, led=0, wr_count=0, and RAM data written before reset still readable afterwards.
